// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: drains a synchronous FIFO with a registered read port and
// presents the words as a valid/ready stream. A 2-entry skid buffer absorbs the
// one-cycle read latency so a consumer holding m_ready high sees one word per
// cycle, with no word lost or repeated.
module fifo_rd_streamer #(
   parameter int unsigned FIFO_WIDTH = 16,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   output logic                  fifo_rd_en,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_empty,
   input  logic                  fifo_underflow,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [FIFO_WIDTH-1:0] m_data,
   output logic [CNT_WIDTH-1:0]  rd_count,
   output logic                  underflow_err,
   output logic                  busy
);

   localparam int unsigned OCC_W = 3;
   localparam logic [OCC_W-1:0] OCC_LIMIT = OCC_W'(2);

   // Skid buffer and bookkeeping registers
   logic [FIFO_WIDTH-1:0] r_buf [2];
   logic                  r_head;
   logic                  r_tail;
   logic [1:0]            r_count;
   logic                  r_pending;
   logic [CNT_WIDTH-1:0]  r_rd_count;
   logic                  r_underflow_err;

   logic                  w_pop;
   logic                  w_capture;
   logic                  w_underflow;
   logic [OCC_W-1:0]      w_occupancy;
   logic                  w_rd_en;
   logic [1:0]            w_count_nxt;

   // Handshake and capture qualifiers
   assign w_pop       = (r_count != 2'd0) & m_ready;
   assign w_capture   = r_pending & ~fifo_underflow;
   assign w_underflow = r_pending & fifo_underflow;

   // Occupancy after this cycle, looking ahead on the pop so a full-rate
   // stream never bubbles; pop implies count >= 1, so this cannot underflow.
   assign w_occupancy = OCC_W'(r_count) + OCC_W'(r_pending) - OCC_W'(w_pop);

   // Pop request: gated by reset so nothing is issued while the FIFO resets
   assign w_rd_en = enable & ~fifo_empty & ~rst & (w_occupancy < OCC_LIMIT);

   // Buffer fill level: capture and pop together leave it unchanged
   always_comb begin
      w_count_nxt = r_count;
      unique case ({w_capture, w_pop})
         2'b10:   w_count_nxt = r_count + 2'd1;
         2'b01:   w_count_nxt = r_count - 2'd1;
         default: w_count_nxt = r_count;
      endcase
   end

   // Pending flag: a pop issued this cycle returns data next cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending <= 1'b0;
      end else begin
         r_pending <= w_rd_en;
      end
   end

   // Skid buffer write side: store a returning word at the tail
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_buf[0] <= '0;
         r_buf[1] <= '0;
         r_tail   <= 1'b0;
      end else if (w_capture) begin
         r_buf[r_tail] <= fifo_data_out;
         r_tail        <= ~r_tail;
      end
   end

   // Skid buffer read side: advance head and count on each delivered word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head     <= 1'b0;
         r_rd_count <= '0;
      end else if (w_pop) begin
         r_head     <= ~r_head;
         r_rd_count <= r_rd_count + CNT_WIDTH'(1);
      end
   end

   // Fill level register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= 2'd0;
      end else begin
         r_count <= w_count_nxt;
      end
   end

   // Sticky underflow flag, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_underflow_err <= 1'b0;
      end else if (w_underflow) begin
         r_underflow_err <= 1'b1;
      end
   end

   assign fifo_rd_en    = w_rd_en;
   assign m_valid       = (r_count != 2'd0);
   assign m_data        = r_buf[r_head];
   assign rd_count      = r_rd_count;
   assign underflow_err = r_underflow_err;
   assign busy          = r_pending | (r_count != 2'd0);

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: a small registered-read FIFO model feeds the DUT;
// per-cycle vectors of inputs and hand-computed outputs are applied and checked.
module tb_fifo_rd_streamer;

   localparam int unsigned W  = 16;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic          fifo_rd_en;
   logic [W-1:0]  fifo_data_out = '0;
   logic          fifo_empty;
   logic          fifo_underflow = 1'b0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [W-1:0]  m_data;
   logic [CW-1:0] rd_count;
   logic          underflow_err;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   // FIFO model storage
   logic [W-1:0] mem [64];
   int           wr_ptr = 0;
   int           rd_ptr = 0;

   fifo_rd_streamer #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .fifo_rd_en     (fifo_rd_en),
      .fifo_data_out  (fifo_data_out),
      .fifo_empty     (fifo_empty),
      .fifo_underflow (fifo_underflow),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .m_data         (m_data),
      .rd_count       (rd_count),
      .underflow_err  (underflow_err),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   assign fifo_empty = (rd_ptr == wr_ptr);

   // Registered-read FIFO model; flushed when reset is seen at a clock edge
   always @(posedge clk) begin
      if (rst) begin
         rd_ptr        <= wr_ptr;
         fifo_data_out <= '0;
      end else if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
         fifo_data_out <= mem[rd_ptr];
         rd_ptr        <= rd_ptr + 1;
      end
   end

   typedef struct {
      logic         rdy;
      logic         en;
      logic         und;
      logic         exp_rd_en;
      logic         exp_valid;
      logic [W-1:0] exp_data;
      logic         exp_busy;
      logic [CW-1:0] exp_cnt;
      logic         exp_err;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic rdy, input logic en, input logic und,
                      input logic rd_en, input logic valid, input logic [W-1:0] data,
                      input logic bsy, input logic [CW-1:0] cnt, input logic err);
      vec_t v;
      v.rdy = rdy; v.en = en; v.und = und;
      v.exp_rd_en = rd_en; v.exp_valid = valid; v.exp_data = data;
      v.exp_busy = bsy; v.exp_cnt = cnt; v.exp_err = err;
      vecs.push_back(v);
   endtask

   // Push words 1..n into the FIFO model
   task automatic load(input int n);
      for (int i = 0; i < n; i++) mem[wr_ptr + i] = W'(i + 1);
      wr_ptr = wr_ptr + n;
   endtask

   task automatic check_outputs(input string tag, input logic rd_en, input logic valid,
                                input logic [W-1:0] data, input logic bsy,
                                input logic [CW-1:0] cnt, input logic err);
      check({tag, " rd_en"}, 32'(fifo_rd_en), 32'(rd_en));
      check({tag, " m_valid"}, 32'(m_valid), 32'(valid));
      if (valid) check({tag, " m_data"}, 32'(m_data), 32'(data));
      check({tag, " busy"}, 32'(busy), 32'(bsy));
      check({tag, " rd_count"}, 32'(rd_count), 32'(cnt));
      check({tag, " underflow_err"}, 32'(underflow_err), 32'(err));
   endtask

   // Apply the vector table one row per cycle; FIFO gets nload words at row 0
   task automatic run_vecs(input string name, input int nload);
      foreach (vecs[i]) begin
         @(negedge clk);
         if (i == 0) load(nload);
         m_ready        = vecs[i].rdy;
         enable         = vecs[i].en;
         fifo_underflow = vecs[i].und;
         #1;
         check_outputs($sformatf("%s[%0d]", name, i), vecs[i].exp_rd_en, vecs[i].exp_valid,
                       vecs[i].exp_data, vecs[i].exp_busy, vecs[i].exp_cnt, vecs[i].exp_err);
      end
      vecs.delete();
   endtask

   // Reset with enable and m_ready high: everything reads zero, no pop issued
   task automatic do_reset(input string name);
      @(negedge clk);
      rst = 1'b1; enable = 1'b1; m_ready = 1'b1; fifo_underflow = 1'b0;
      #1;
      check_outputs(name, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      check({name, " m_data"}, 32'(m_data), 32'h0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      // Reset with data sitting in the FIFO
      load(3);
      enable = 1'b1; m_ready = 1'b1;
      #1;
      check("reset fifo_not_empty", 32'(fifo_empty), 32'h0);
      check_outputs("reset", 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      check("reset m_data", 32'(m_data), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_reset fifo flushed rd_en", 32'(fifo_rd_en), 32'h0);

      // Streaming: 8 words at full rate
      //  rdy en und rd_en valid data  busy cnt err
      add(1, 1, 0, 1, 0, 16'h0, 0, 0, 0);
      add(1, 1, 0, 1, 0, 16'h0, 1, 0, 0);
      add(1, 1, 0, 1, 1, 16'h1, 1, 0, 0);
      add(1, 1, 0, 1, 1, 16'h2, 1, 1, 0);
      add(1, 1, 0, 1, 1, 16'h3, 1, 2, 0);
      add(1, 1, 0, 1, 1, 16'h4, 1, 3, 0);
      add(1, 1, 0, 1, 1, 16'h5, 1, 4, 0);
      add(1, 1, 0, 1, 1, 16'h6, 1, 5, 0);
      add(1, 1, 0, 0, 1, 16'h7, 1, 6, 0);
      add(1, 1, 0, 0, 1, 16'h8, 1, 7, 0);
      add(1, 1, 0, 0, 0, 16'h0, 0, 8, 0);
      run_vecs("stream", 8);
      do_reset("rst1");

      // Backpressure: 4 words, consumer stalled 10 cycles
      add(0, 1, 0, 1, 0, 16'h0, 0, 0, 0);
      add(0, 1, 0, 1, 0, 16'h0, 1, 0, 0);
      for (int i = 0; i < 8; i++) add(0, 1, 0, 0, 1, 16'h1, 1, 0, 0);
      add(1, 1, 0, 1, 1, 16'h1, 1, 0, 0);
      add(1, 1, 0, 1, 1, 16'h2, 1, 1, 0);
      add(1, 1, 0, 0, 1, 16'h3, 1, 2, 0);
      add(1, 1, 0, 0, 1, 16'h4, 1, 3, 0);
      add(1, 1, 0, 0, 0, 16'h0, 0, 4, 0);
      run_vecs("bp", 4);
      do_reset("rst2");

      // Enable drop with a pop pending, m_ready toggling
      add(1, 1, 0, 1, 0, 16'h0, 0, 0, 0);
      add(0, 1, 0, 1, 0, 16'h0, 1, 0, 0);
      add(1, 1, 0, 1, 1, 16'h1, 1, 0, 0);
      add(0, 0, 0, 0, 1, 16'h2, 1, 1, 0);
      add(1, 0, 0, 0, 1, 16'h2, 1, 1, 0);
      add(0, 0, 0, 0, 1, 16'h3, 1, 2, 0);
      add(1, 0, 0, 0, 1, 16'h3, 1, 2, 0);
      add(0, 0, 0, 0, 0, 16'h0, 0, 3, 0);
      add(1, 0, 0, 0, 0, 16'h0, 0, 3, 0);
      run_vecs("enable", 6);
      do_reset("rst3");

      // Underflow on the first returning read: word 1 dropped, flag sticks
      add(1, 1, 0, 1, 0, 16'h0, 0, 0, 0);
      add(1, 1, 1, 1, 0, 16'h0, 1, 0, 0);
      add(1, 1, 0, 0, 0, 16'h0, 1, 0, 1);
      add(1, 1, 0, 0, 1, 16'h2, 1, 0, 1);
      add(1, 1, 0, 0, 0, 16'h0, 0, 1, 1);
      add(1, 1, 0, 0, 0, 16'h0, 0, 1, 1);
      add(1, 1, 0, 0, 0, 16'h0, 0, 1, 1);
      run_vecs("underflow", 2);
      do_reset("rst4");

      // Counter wrap: 17 words through a 4-bit counter
      @(negedge clk);
      load(17);
      enable = 1'b1; m_ready = 1'b1; fifo_underflow = 1'b0;
      repeat (17) @(negedge clk);
      #1;
      check("wrap after15 rd_count", 32'(rd_count), 32'hF);
      check("wrap after15 m_data", 32'(m_data), 32'h10);
      @(negedge clk);
      #1;
      check("wrap after16 rd_count", 32'(rd_count), 32'h0);
      check("wrap after16 m_data", 32'(m_data), 32'h11);
      check("wrap after16 m_valid", 32'(m_valid), 32'h1);
      @(negedge clk);
      #1;
      check("wrap after17 rd_count", 32'(rd_count), 32'h1);
      check("wrap after17 m_valid", 32'(m_valid), 32'h0);
      check("wrap after17 busy", 32'(busy), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_rd_streamer.md
# fifo_rd_streamer

Read-side drain for the synchronous FIFO: issues `rd_en` pops against the FIFO's registered read port and presents the words downstream as a valid/ready stream. A 2-entry skid buffer absorbs the FIFO's one-cycle read latency, so a consumer holding `m_ready` high sees one word per cycle with no loss or duplication. It sits between the FIFO read port and any consumer, and is the counterpart to the write-side stimulus/producer.

## Interface
- `FIFO_WIDTH`, default 16: data width; must match the FIFO.
- `CNT_WIDTH`, default 16: width of the delivered-word counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  when low, no new pops are issued; in-flight and buffered words still drain.
- `fifo_rd_en`  out  1  pop request to the FIFO.
- `fifo_data_out`  in  FIFO_WIDTH  FIFO read data; valid the cycle after an accepted pop.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_underflow`  in  1  FIFO underflow flag; qualifies the returning read.
- `m_valid`  out  1  output word available.
- `m_ready`  in  1  consumer accepts the word.
- `m_data`  out  FIFO_WIDTH  output word, the buffer head.
- `rd_count`  out  CNT_WIDTH  count of words delivered downstream; wraps modulo 2^CNT_WIDTH.
- `underflow_err`  out  1  sticky; set when the FIFO reports underflow on a returning read.
- `busy`  out  1  `pending` OR buffer non-empty.

## Operation
- **State:**
  - `pending` (1 bit): a pop was issued last cycle.
  - Buffer: 2 entries, 1-bit head/tail pointers, `count` in {0,1,2}.
  - `rd_count`.
  - `underflow_err`.
- **Pop signal:** `pop = m_valid & m_ready`.
  - `m_valid = (count != 0)`.
  - `m_data = buf[head]`.
- **Pop issue:** `fifo_rd_en = enable & ~fifo_empty & ~rst & (count + pending - pop < 2)`.
  - The look-ahead on `pop` is required for full throughput.
  - The invariant `count + pending <= 2` holds at every edge.
- **Capture:** when `pending` = 1 and `fifo_underflow` = 0, write `fifo_data_out` to `buf[tail]` and advance `tail`.
- **Underflow:** when `pending` = 1 and `fifo_underflow` = 1, capture nothing and set `underflow_err`. The flag stays set until `rst`.
- **Pending update:** `pending <= fifo_rd_en`.
- **Simultaneous capture and pop:** `count` is unchanged; head and tail both advance.
- **Counter:** on each `pop`, `head` advances and `rd_count` increments, wrapping from all-ones to 0.
- **`enable` deasserted mid-stream:** no new `fifo_rd_en` from that cycle. A pending word is still captured, and buffered words are still delivered.
- **`m_ready` low with a full buffer:** `fifo_rd_en` stays 0, and `m_data` stays stable while `m_valid` is high.
- **Width:** `count + pending - pop` is computed in 3 bits; this cannot underflow because `pop` implies `count >= 1`.

## Timing
- **Reset values** (`rst` high, asynchronously):
  - `fifo_rd_en` = 0, `m_valid` = 0, `m_data` = 0.
  - `rd_count` = 0, `underflow_err` = 0, `busy` = 0.
  - `pending` = 0, `count` = 0, `head` = 0, `tail` = 0.
  - Buffer contents = 0.
- **Reset mid-operation:** any in-flight word is discarded. The FIFO is expected to be reset in the same cycle.
- **Latency:**
  - `fifo_rd_en` high in cycle T.
  - `fifo_data_out` valid in T+1 and captured at the end of T+1.
  - `m_valid` is high in T+2.
  - Minimum FIFO-not-empty to `m_valid` is 2 cycles.
- **Throughput:** with `m_ready` held at 1 and the FIFO non-empty, `fifo_rd_en` and `m_valid` are both high every cycle in steady state.
- **Combinational paths:**
  - `fifo_rd_en` depends combinationally on `m_ready`, `fifo_empty` and `enable`.
  - `m_valid` and `m_data` are register outputs only.
- **Handshake:** once `m_valid` is asserted it stays high, with `m_data` stable, until `pop`.

## Test plan
- **Reset:** assert `rst` while the FIFO holds data and `enable` = 1. Required: all outputs 0 during reset; `fifo_rd_en` = 0.
- **Streaming:** FIFO preloaded with 8 words 0x0001..0x0008, `m_ready` = 1, `enable` = 1.
  - `fifo_rd_en` is high for exactly 8 cycles.
  - `m_valid` is first high 2 cycles after the first pop and delivers 0x0001..0x0008 on consecutive cycles.
  - `rd_count` = 8 afterwards; `busy` = 0 afterwards.
- **Backpressure:** 4 words queued, `m_ready` = 0 for 10 cycles, then 1.
  - During the stall: exactly 2 pops, `count` = 2, `m_data` = 0x0001 stable, `fifo_rd_en` = 0.
  - After release: 0x0001..0x0004 delivered in order with no gaps.
- **Enable and concurrent capture/pop:** with `m_ready` toggling every cycle, drop `enable` while a pop is pending.
  - The pending word is still delivered, and no further `fifo_rd_en` is issued.
  - Word order and `rd_count` stay exact across cycles where a capture and a pop happen together.
- **Underflow:** force `fifo_underflow` = 1 in the cycle after a pop. Required: no word is captured, `underflow_err` = 1 and stays 1 until `rst`, and `rd_count` is unchanged.
- **Counter wrap:** with `CNT_WIDTH` = 4, deliver 17 words. Required: `rd_count` reads 0xF after 15 words, 0x0 after 16, and 0x1 after 17.
